// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared types and constants for the sram-like to AXI data-side bridge.
// Holds the FSM state encoding, the access-size codes and the default AXI ID.
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StRd,
        StAwW,
        StBr,
        StResp
    } state_e;

    localparam logic [1:0] SzB = 2'd0;
    localparam logic [1:0] SzH = 2'd1;
    localparam logic [1:0] SzW = 2'd2;

    localparam logic [3:0] DefaultAxiId = 4'd1;

    // Size code 3 is not a legal sram-like size; it is carried as a word access.
    function automatic logic [1:0] legal_size(input logic [1:0] size);
        return (size == 2'd3) ? SzW : size;
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Uncached data-side bridge: one sram-like request at a time becomes a single-beat
// AXI read or write, answered by a one-cycle data_data_ok pulse.
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = DefaultAxiId
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        data_ok_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic        aw_fin;
    logic        w_fin;

    // A channel counts as finished if it completed earlier or handshakes right now.
    assign aw_fin = aw_done_q | (awvalid_q & awready);
    assign w_fin  = w_done_q  | (wvalid_q & wready);

    assign data_addr_ok = (state_q == StIdle) & data_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rdata_q   <= 32'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (data_req) begin
                        size_q  <= legal_size(data_size);
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        wstrb_q <= data_wstrb;
                        if (data_wr) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StAwW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StAr;
                        end
                    end
                end
                StAr: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRd;
                    end
                end
                StRd: begin
                    if (rvalid) begin
                        rready_q  <= 1'b0;
                        rdata_q   <= rdata;
                        data_ok_q <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StAwW: begin
                    if (awvalid_q && awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // Later assignments here override the done-flag sets above.
                    if (aw_fin && w_fin) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StBr;
                    end
                end
                StBr: begin
                    if (bvalid) begin
                        bready_q  <= 1'b0;
                        data_ok_q <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    data_ok_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_data_ok = data_ok_q;
    assign data_rdata   = rdata_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign wlast   = 1'b1;
    assign bready  = bready_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Scoreboard bench for data_sram_axi_bridge: a memory-backed AXI slave with per-transaction
// latencies, a word-array reference model, and a monitor that pops expected responses.
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    data_sram_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_ok_cyc = -100;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    resp_t resp_q[$];
    req_t  ar_q[$];
    req_t  aw_q[$];
    req_t  w_q[$];

    logic [31:0] ref_mem[256];
    logic [31:0] smem[256];

    // Slave latency knobs, set when a request is accepted.
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;

    // AXI slave: decides readies/responses at negedge+2 for the coming posedge.
    initial begin
        bit          rd_pend = 0, aw_got = 0, w_got = 0, wr_done = 0;
        int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
        logic [31:0] s_rd_addr = 0, s_aw_addr = 0, s_wdata = 0;
        logic [3:0]  s_wstrb = 0;
        arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
        forever begin
            @(negedge clk);
            #2;
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            if (reset) begin
                rd_pend = 0; aw_got = 0; w_got = 0; wr_done = 0;
                ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                if (rd_pend) begin
                    if (r_wait >= r_lat) begin
                        rvalid = 1;
                        rdata = smem[s_rd_addr[9:2]];
                        if (rready) rd_pend = 0;
                    end else r_wait++;
                end
                if (aw_got && w_got) begin
                    if (!wr_done) begin
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) smem[s_aw_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
                        wr_done = 1;
                    end
                    if (b_wait >= b_lat) begin
                        bvalid = 1;
                        if (bready) begin aw_got = 0; w_got = 0; wr_done = 0; end
                    end else b_wait++;
                end
                if (arvalid && !rd_pend) begin
                    if (ar_wait >= ar_lat) begin
                        arready = 1; rd_pend = 1; s_rd_addr = araddr; r_wait = 0; ar_wait = 0;
                    end else ar_wait++;
                end
                if (awvalid && !aw_got) begin
                    if (aw_wait >= aw_lat) begin
                        awready = 1; aw_got = 1; s_aw_addr = awaddr; aw_wait = 0; b_wait = 0;
                    end else aw_wait++;
                end
                if (wvalid && !w_got) begin
                    if (w_wait >= w_lat) begin
                        wready = 1; w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
                        w_wait = 0; b_wait = 0;
                    end else w_wait++;
                end
            end
        end
    end

    // Monitor: samples at negedge+3, after stimulus and slave have settled.
    initial begin
        resp_t r;
        req_t  e;
        bit p_ar_hs = 0, p_aw_hs = 0, p_w_hs = 0, p_r_hs = 0, p_b_hs = 0;
        bit p_ar_wait = 0, p_aw_wait = 0, p_w_wait = 0, p_r_wait = 0;
        logic [31:0] p_araddr = 0, p_awaddr = 0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                p_ar_hs = 0; p_aw_hs = 0; p_w_hs = 0; p_r_hs = 0; p_b_hs = 0;
                p_ar_wait = 0; p_aw_wait = 0; p_w_wait = 0; p_r_wait = 0;
                continue;
            end
            if (data_data_ok) begin
                chk("addr_ok_during_resp", 32'(data_addr_ok), 32'd0);
                if (resp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_data_ok: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r = resp_q.pop_front();
                    if (!r.is_wr) chk("load_data", data_rdata, r.rdata);
                    if (r.lat >= 0) chk("latency", 32'(cyc - r.acc), 32'(r.lat));
                    last_ok_cyc = cyc;
                end
            end
            if (p_ar_hs) chk("arvalid_drop", 32'(arvalid), 32'd0);
            if (p_aw_hs) chk("awvalid_drop", 32'(awvalid), 32'd0);
            if (p_w_hs)  chk("wvalid_drop", 32'(wvalid), 32'd0);
            if (p_r_hs)  chk("rready_drop", 32'(rready), 32'd0);
            if (p_b_hs)  chk("bready_drop", 32'(bready), 32'd0);
            if (p_ar_wait) begin
                chk("arvalid_hold", 32'(arvalid), 32'd1);
                chk("araddr_stable", araddr, p_araddr);
            end
            if (p_aw_wait) begin
                chk("awvalid_hold", 32'(awvalid), 32'd1);
                chk("awaddr_stable", awaddr, p_awaddr);
            end
            if (p_w_wait) chk("wvalid_hold", 32'(wvalid), 32'd1);
            if (p_r_wait) chk("rready_hold", 32'(rready), 32'd1);
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ar: got handshake expected none (cycle %0d)", cyc);
                end else begin
                    e = ar_q.pop_front();
                    chk("araddr", araddr, e.addr);
                    chk("arsize", 32'(arsize), 32'(e.size));
                    chk("arid", 32'(arid), 32'd1);
                end
            end
            if (awvalid && awready) begin
                if (aw_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_aw: got handshake expected none (cycle %0d)", cyc);
                end else begin
                    e = aw_q.pop_front();
                    chk("awaddr", awaddr, e.addr);
                    chk("awsize", 32'(awsize), 32'(e.size));
                    chk("awid", 32'(awid), 32'd1);
                end
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_w: got handshake expected none (cycle %0d)", cyc);
                end else begin
                    e = w_q.pop_front();
                    chk("wdata", wdata, e.wdata);
                    chk("wstrb", 32'(wstrb), 32'(e.wstrb));
                    chk("wlast", 32'(wlast), 32'd1);
                end
            end
            p_ar_hs = arvalid && arready;  p_ar_wait = arvalid && !arready;
            p_aw_hs = awvalid && awready;  p_aw_wait = awvalid && !awready;
            p_w_hs  = wvalid && wready;    p_w_wait  = wvalid && !wready;
            p_r_hs  = rvalid && rready;    p_r_wait  = rready && !rvalid;
            p_b_hs  = bvalid && bready;
            p_araddr = araddr; p_awaddr = awaddr;
        end
    end

    // Called at a negedge; leaves data_req high and returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input bit b2b,
                         input int l_ar, input int l_r, input int l_aw, input int l_w,
                         input int l_b);
        int   k = 0;
        int   lat;
        req_t q;
        data_req = 1; data_wr = wr; data_size = size;
        data_addr = addr; data_wdata = wd; data_wstrb = ws;
        #1;
        while (!data_addr_ok) begin
            if (k == 300) begin
                n_vec++; n_err++;
                $display("FAIL accept_timeout: data_addr_ok got 0 expected 1 (cycle %0d)", cyc);
                data_req = 0;
                return;
            end
            k++;
            @(negedge clk);
            #1;
        end
        if (b2b) chk("b2b_accept_cycle", 32'(cyc), 32'(last_ok_cyc + 1));
        ar_lat = l_ar; r_lat = l_r; aw_lat = l_aw; w_lat = l_w; b_lat = l_b;
        q.addr = addr; q.wdata = wd; q.wstrb = ws;
        q.size = (size == 2'd3) ? 3'b010 : {1'b0, size};
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (ws[b]) ref_mem[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
            lat = 3 + ((l_aw > l_w) ? l_aw : l_w) + l_b;
            aw_q.push_back(q);
            w_q.push_back(q);
            resp_q.push_back('{1'b1, 32'd0, cyc, lat});
        end else begin
            lat = 3 + l_ar + l_r;
            ar_q.push_back(q);
            resp_q.push_back('{1'b0, ref_mem[addr[9:2]], cyc, lat});
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(rready), 32'd0);
        chk({tag, "_awvalid"}, 32'(awvalid), 32'd0);
        chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        chk({tag, "_bready"}, 32'(bready), 32'd0);
        chk({tag, "_data_ok"}, 32'(data_data_ok), 32'd0);
        chk({tag, "_data_rdata"}, data_rdata, 32'd0);
        chk({tag, "_addr_ok"}, 32'(data_addr_ok), 32'd0);
    endtask

    task automatic drain();
        int k = 0;
        data_req = 0;
        while (resp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending_responses", 32'(resp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          l_a, l_b2;
        reset = 1; data_req = 0; data_wr = 0; data_size = 0;
        data_addr = 0; data_wdata = 0; data_wstrb = 0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            smem[i] = v;
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        smem[4] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        reset = 0;
        #4;
        check_idle_outputs("reset");
        @(negedge clk);

        // Zero-wait read.
        issue(1'b0, 2'd2, 32'h1FC0_0010, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0);
        drain();
        // Byte store with awready two cycles late, then read it back.
        @(negedge clk);
        issue(1'b1, 2'd0, 32'h0000_0103, 32'hAB00_0000, 4'b1000, 1'b0, 0, 0, 2, 0, 0);
        issue(1'b0, 2'd2, 32'h0000_0100, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0);
        drain();
        // Back-to-back loads with data_req held high.
        @(negedge clk);
        issue(1'b0, 2'd2, 32'h0000_0020, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0);
        issue(1'b0, 2'd2, 32'h0000_0024, 32'd0, 4'd0, 1'b1, 0, 0, 0, 0, 0);
        drain();
        // rvalid withheld five cycles.
        @(negedge clk);
        issue(1'b0, 2'd1, 32'h0000_0042, 32'd0, 4'd0, 1'b0, 0, 5, 0, 0, 0);
        drain();
        // Reset while waiting in the read-data phase, then a fresh load.
        @(negedge clk);
        issue(1'b0, 2'd2, 32'h0000_0080, 32'd0, 4'd0, 1'b0, 0, 20, 0, 0, 0);
        data_req = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        resp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
        @(negedge clk);
        reset = 0;
        #4;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        issue(1'b0, 2'd2, 32'h0000_0080, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0);
        drain();
        // wready long before awready.
        @(negedge clk);
        issue(1'b1, 2'd2, 32'h0000_0200, 32'h1234_5678, 4'b1111, 1'b0, 0, 0, 3, 0, 0);
        // Illegal size 3 is issued as a word access.
        issue(1'b0, 2'd3, 32'h0000_0200, 32'd0, 4'd0, 1'b0, 0, 0, 0, 0, 0);
        drain();

        // Randomised traffic.
        for (int t = 0; t < 300; t++) begin
            l_a = $urandom_range(0, 3);
            l_b2 = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 1'b0, l_a, l_b2, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                data_req = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();
        chk("ar_queue_empty", 32'(ar_q.size()), 32'd0);
        chk("aw_queue_empty", 32'(aw_q.size()), 32'd0);
        chk("w_queue_empty", 32'(w_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
